// File: rtl/spine_node_router_if.sv
// Bus bundle for the spine node router: local (NI) port plus packed spine ports.
// The router connects through the slave modport. The NI/fabric side connects through the master modport.
interface spine_node_router_if #(
    parameter int NUM_SPINES = 4,
    parameter int DWIDTH     = 16
);
    logic [DWIDTH-1:0]            loc_in_data;
    logic                         loc_in_valid;
    logic                         loc_in_ready;
    logic [DWIDTH-1:0]            loc_out_data;
    logic                         loc_out_valid;
    logic                         loc_out_ready;
    logic [NUM_SPINES*DWIDTH-1:0] spine_in_data;
    logic [NUM_SPINES-1:0]        spine_in_valid;
    logic [NUM_SPINES-1:0]        spine_in_ready;
    logic [NUM_SPINES*DWIDTH-1:0] spine_out_data;
    logic [NUM_SPINES-1:0]        spine_out_valid;
    logic [NUM_SPINES-1:0]        spine_out_ready;
    logic [15:0]                  stat_fwd_count;

    modport master (
        output loc_in_data, loc_in_valid, loc_out_ready,
        output spine_in_data, spine_in_valid, spine_out_ready,
        input  loc_in_ready, loc_out_data, loc_out_valid,
        input  spine_in_ready, spine_out_data, spine_out_valid,
        input  stat_fwd_count
    );

    modport slave (
        input  loc_in_data, loc_in_valid, loc_out_ready,
        input  spine_in_data, spine_in_valid, spine_out_ready,
        output loc_in_ready, loc_out_data, loc_out_valid,
        output spine_in_ready, spine_out_data, spine_out_valid,
        output stat_fwd_count
    );
endinterface

// File: rtl/spine_node_router.sv
// Spine node router tile. Port 0 is the local NI port, and ports 1..NUM_SPINES are the spines.
// Each input has a FIFO. Each output has a round-robin arbiter that feeds a registered output stage.
// Flits never drop: backpressure propagates through valid/ready.
module spine_node_router #(
    parameter int NUM_SPINES = 4,
    parameter int DWIDTH     = 16,
    parameter int ADDR_W     = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int NODE_ID    = 19
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    spine_node_router_if.slave  bus
);
    localparam int NP = NUM_SPINES + 1;
    localparam int SW = $clog2(NUM_SPINES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(NP);

    // The output port depends on the dest field of the head flit.
    function automatic logic [PW-1:0] route(input logic [ADDR_W-1:0] dest);
        if (dest == ADDR_W'(NODE_ID)) return '0;
        return PW'(1) + PW'(dest[SW-1:0]);
    endfunction

    // Number of output handshakes completed in this cycle.
    function automatic logic [PW:0] count_ones(input logic [NP-1:0] v);
        logic [PW:0] c;
        c = '0;
        for (int i = 0; i < NP; i++) c = c + (PW+1)'(v[i]);
        return c;
    endfunction

    // Adds to the counter and clamps the result at all-ones.
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [PW:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [DWIDTH-1:0] in_data   [NP];
    logic [DWIDTH-1:0] head      [NP];
    logic [DWIDTH-1:0] out_data  [NP];
    logic [DWIDTH-1:0] mem       [NP][FIFO_DEPTH];
    logic [AW:0]       wr_ptr    [NP];
    logic [AW:0]       rd_ptr    [NP];
    logic [PW-1:0]     tgt       [NP];
    logic [PW-1:0]     gnt_idx   [NP];
    logic [PW-1:0]     ptr       [NP];
    logic [NP-1:0]     in_valid, full, empty, push, pop;
    logic [NP-1:0]     out_valid, out_ready, gnt_vld;
    logic [15:0]       stat;

    assign in_valid  = {bus.spine_in_valid, bus.loc_in_valid};
    assign out_ready = {bus.spine_out_ready, bus.loc_out_ready};
    assign in_data[0] = bus.loc_in_data;

    assign bus.loc_in_ready    = ~full[0];
    assign bus.spine_in_ready  = ~full[NP-1:1];
    assign bus.loc_out_valid   = out_valid[0];
    assign bus.spine_out_valid = out_valid[NP-1:1];
    assign bus.loc_out_data    = out_data[0];
    assign bus.stat_fwd_count  = stat;

    for (genvar s = 0; s < NUM_SPINES; s++) begin : g_pack
        assign in_data[s+1] = bus.spine_in_data[s*DWIDTH +: DWIDTH];
        assign bus.spine_out_data[s*DWIDTH +: DWIDTH] = out_data[s+1];
    end

    // FIFO status, head flit and route target for each input.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                       (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
            push[i]  = in_valid[i] && !full[i];
            head[i]  = mem[i][rd_ptr[i][AW-1:0]];
            tgt[i]   = route(head[i][DWIDTH-1 -: ADDR_W]);
        end
    end

    // Per-output round-robin search starts after the last input granted.
    // Each head routes to one output only, so an input is never granted to two outputs.
    always_comb begin : arb
        int idx;
        idx     = 0;
        gnt_vld = '0;
        pop     = '0;
        for (int o = 0; o < NP; o++) begin
            gnt_idx[o] = '0;
            for (int k = 1; k <= NP; k++) begin
                idx = (int'(ptr[o]) + k) % NP;
                if (!gnt_vld[o] && (!out_valid[o] || out_ready[o]) &&
                    !empty[idx] && tgt[idx] == PW'(o)) begin
                    gnt_vld[o] = 1'b1;
                    gnt_idx[o] = PW'(idx);
                end
            end
            if (gnt_vld[o]) pop[gnt_idx[o]] = 1'b1;
        end
    end

    // Write path of the FIFO storage. The contents need no reset because the pointers define validity.
    always_ff @(posedge ACLK) begin
        for (int i = 0; i < NP; i++)
            if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= in_data[i];
    end

    // FIFO pointers. A reset empties every queue and discards any in-flight flit.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NP; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
        end
    end

    // Arbiter pointers move only when their output grants.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int o = 0; o < NP; o++) ptr[o] <= '0;
        end else begin
            for (int o = 0; o < NP; o++)
                if (gnt_vld[o]) ptr[o] <= gnt_idx[o];
        end
    end

    // The output register loads on a grant and otherwise holds until its handshake.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            out_valid <= '0;
            for (int o = 0; o < NP; o++) out_data[o] <= '0;
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (gnt_vld[o]) begin
                    out_valid[o] <= 1'b1;
                    out_data[o]  <= head[gnt_idx[o]];
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
        end
    end

    // Count delivered flits across all outputs, saturating at the maximum value.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) stat <= '0;
        else          stat <= sat_add(stat, count_ones(out_valid & out_ready));
    end
endmodule

// File: tb/tb_spine_node_router.sv
// Directed testbench for spine_node_router with the default parameters (4 spines, 16-bit flits, node 19).
module tb_spine_node_router;
    localparam int NS = 4;
    localparam int DW = 16;

    logic ACLK = 1'b0;
    logic ARESETn;
    int   vectors = 0;
    int   miscompares = 0;

    int          tag_of [4] = '{0, 1, 2, 4};
    logic [15:0] rec [$];
    logic [15:0] got;
    int          first_cyc, last_cyc, remaining, guard;
    logic [4:0]  en;
    logic        took;

    spine_node_router_if #(.NUM_SPINES(NS), .DWIDTH(DW)) bus ();

    spine_node_router #(
        .NUM_SPINES(NS), .DWIDTH(DW), .ADDR_W(6), .FIFO_DEPTH(4), .NODE_ID(19)
    ) dut (
        .ACLK(ACLK),
        .ARESETn(ARESETn),
        .bus(bus)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_spine(input int s, input logic [15:0] v);
        bus.spine_in_data[s*DW +: DW] = v;
    endtask

    // Sends one flit on the local input, then lets it drain through an idle output.
    task automatic local_one(input logic [15:0] v);
        bus.loc_in_valid = 1'b1;
        bus.loc_in_data  = v;
        tick();
        bus.loc_in_valid = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        ARESETn = 1'b0;
        bus.loc_in_data = '0;
        bus.loc_in_valid = 1'b0;
        bus.loc_out_ready = 1'b1;
        bus.spine_in_data = '0;
        bus.spine_in_valid = '0;
        bus.spine_out_ready = '1;
        tick();
        tick();
        check("rst_loc_out_valid", bus.loc_out_valid, 0);
        check("rst_spine_out_valid", bus.spine_out_valid, 0);
        check("rst_loc_in_ready", bus.loc_in_ready, 1);
        check("rst_spine_in_ready", bus.spine_in_ready, 4'hF);
        check("rst_count", bus.stat_fwd_count, 0);
        check("rst_loc_out_data", bus.loc_out_data, 0);
        check("rst_spine_out_data", bus.spine_out_data, 0);
        ARESETn = 1'b1;
        tick();

        // T2: spine 2 delivers to the local port
        bus.spine_in_valid = 4'b0100;
        set_spine(2, 16'h4C12);
        tick();
        bus.spine_in_valid = '0;
        check("t2_valid_k", bus.loc_out_valid, 0);
        tick();
        check("t2_valid_k1", bus.loc_out_valid, 1);
        check("t2_data", bus.loc_out_data, 16'h4C12);
        check("t2_no_spine", bus.spine_out_valid, 0);
        tick();
        check("t2_count", bus.stat_fwd_count, 1);
        check("t2_valid_after", bus.loc_out_valid, 0);

        // T3: local sends to dest 5, which routes to spine 1
        bus.loc_in_valid = 1'b1;
        bus.loc_in_data  = 16'h1401;
        tick();
        bus.loc_in_valid = 1'b0;
        check("t3_valid_k", bus.spine_out_valid, 0);
        tick();
        check("t3_valid", bus.spine_out_valid, 4'b0010);
        check("t3_data", bus.spine_out_data[31:16], 16'h1401);
        check("t3_no_local", bus.loc_out_valid, 0);
        tick();
        check("t3_count", bus.stat_fwd_count, 2);

        // spine 3 to local, which leaves the local arbiter pointer at spine 3
        bus.spine_in_valid = 4'b1000;
        set_spine(3, 16'h4C3F);
        tick();
        bus.spine_in_valid = '0;
        tick();
        check("pre_data", bus.loc_out_data, 16'h4C3F);
        tick();
        check("pre_count", bus.stat_fwd_count, 3);

        // T4: round-robin among local, S0, S1 and S3, all sending to the local port
        first_cyc = -1;
        last_cyc  = -1;
        rec.delete();
        for (int c = 0; c < 24; c++) begin
            if (c < 4) begin
                bus.loc_in_valid = 1'b1;
                bus.loc_in_data  = 16'h4C00 | 16'(c);
                bus.spine_in_valid = 4'b1011;
                set_spine(0, 16'h4C10 | 16'(c));
                set_spine(1, 16'h4C20 | 16'(c));
                set_spine(3, 16'h4C40 | 16'(c));
            end else begin
                bus.loc_in_valid = 1'b0;
                bus.spine_in_valid = '0;
            end
            tick();
            if (bus.loc_out_valid) begin
                rec.push_back(bus.loc_out_data);
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
            end
        end
        check("t4_flit_total", rec.size(), 16);
        check("t4_span", last_cyc - first_cyc, 15);
        for (int n = 0; n < 16; n++) begin
            got = (n < rec.size()) ? rec[n] : 16'hxxxx;
            check($sformatf("t4_flit%0d", n), got, 16'h4C00 | 16'(tag_of[n % 4] << 4) | 16'(n / 4));
        end
        check("t4_count", bus.stat_fwd_count, 19);

        // T5: spine 0 output is stalled, and local pushes six flits to dest 4
        bus.spine_out_ready = 4'b1110;
        for (int f = 1; f <= 5; f++) begin
            bus.loc_in_valid = 1'b1;
            bus.loc_in_data  = 16'h1000 | 16'(f);
            check($sformatf("t5_ready%0d", f), bus.loc_in_ready, 1);
            tick();
        end
        bus.loc_in_data = 16'h1006;
        for (int h = 0; h < 3; h++) begin
            check($sformatf("t5_full%0d", h), bus.loc_in_ready, 0);
            check($sformatf("t5_hold_v%0d", h), bus.spine_out_valid[0], 1);
            check($sformatf("t5_hold_d%0d", h), bus.spine_out_data[15:0], 16'h1001);
            tick();
        end
        bus.spine_out_ready = 4'hF;
        rec.delete();
        for (int c = 0; c < 20; c++) begin
            if (bus.spine_out_valid[0]) rec.push_back(bus.spine_out_data[15:0]);
            took = bus.loc_in_valid && bus.loc_in_ready;
            tick();
            if (took) bus.loc_in_valid = 1'b0;
        end
        check("t5_accepted6", bus.loc_in_valid, 0);
        check("t5_flit_total", rec.size(), 6);
        for (int n = 0; n < 6; n++) begin
            got = (n < rec.size()) ? rec[n] : 16'hxxxx;
            check($sformatf("t5_flit%0d", n + 1), got, 16'h1001 + 16'(n));
        end
        check("t5_count", bus.stat_fwd_count, 25);

        // T1: asynchronous reset in the middle of traffic
        bus.loc_out_ready = 1'b0;
        bus.loc_in_valid = 1'b1;
        bus.loc_in_data = 16'h4C01;
        tick();
        bus.loc_in_data = 16'h4C02;
        tick();
        bus.loc_in_valid = 1'b0;
        tick();
        check("t1_pre_valid", bus.loc_out_valid, 1);
        ARESETn = 1'b0;
        #1;
        check("t1_loc_out_valid", bus.loc_out_valid, 0);
        check("t1_spine_out_valid", bus.spine_out_valid, 0);
        check("t1_loc_in_ready", bus.loc_in_ready, 1);
        check("t1_spine_in_ready", bus.spine_in_ready, 4'hF);
        check("t1_count", bus.stat_fwd_count, 0);
        tick();
        ARESETn = 1'b1;
        bus.loc_out_ready = 1'b1;
        tick();
        tick();
        tick();
        check("t1_discarded", bus.loc_out_valid, 0);
        check("t1_count_after", bus.stat_fwd_count, 0);

        // T6: stream exactly 65534 flits on all five ports, then push the count past saturation
        remaining = 65534;
        guard = 0;
        bus.loc_in_data = 16'h4C00;
        for (int s = 0; s < NS; s++) set_spine(s, 16'(s) << 10);
        while (remaining > 0 && guard < 20000) begin
            en = '0;
            if (bus.loc_in_ready && remaining > 0) begin
                en[0] = 1'b1;
                remaining--;
            end
            for (int s = 0; s < NS; s++) begin
                if (bus.spine_in_ready[s] && remaining > 0) begin
                    en[s+1] = 1'b1;
                    remaining--;
                end
            end
            bus.loc_in_valid = en[0];
            bus.spine_in_valid = en[4:1];
            tick();
            guard++;
        end
        bus.loc_in_valid = 1'b0;
        bus.spine_in_valid = '0;
        check("t6_stream_done", remaining, 0);
        repeat (10) tick();
        check("t6_preload", bus.stat_fwd_count, 16'hFFFE);
        local_one(16'h4C01);
        check("t6_sat1", bus.stat_fwd_count, 16'hFFFF);
        local_one(16'h4C02);
        local_one(16'h4C03);
        check("t6_sat3", bus.stat_fwd_count, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
